// File: rtl/mandel_iter_sequencer.sv
// Mandelbrot iteration sequencer: runs z <= z^2 + c for one pixel, sharing one
// external fixed-point multiplier over three phases per iteration, and reports the escape count.
module mandel_iter_sequencer #(
  parameter int D  = 8,
  parameter int F  = 24,
  parameter int IW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [D+F-1:0]   c_re,
  input  logic [D+F-1:0]   c_im,
  input  logic [IW-1:0]    max_iter,
  output logic [D+F-1:0]   mult_a,
  output logic [D+F-1:0]   mult_b,
  input  logic [D+F-1:0]   mult_p,
  output logic             busy,
  output logic             done,
  output logic             escaped,
  output logic [IW-1:0]    iter_count,
  output logic [2:0]       state_dbg
);

  localparam int W = D + F;
  localparam logic signed [W:0] MAG_LIMIT = (W+1)'(64'd4 << F);

  // Handshake: start is a single-cycle request accepted only in IDLE (busy=0);
  // done is a one-cycle pulse with escaped/iter_count valid in that cycle and held afterwards.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RR   = 3'd1,
    S_II   = 3'd2,
    S_RI   = 3'd3,
    S_UPD  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t          state, state_next;
  logic [W-1:0]    zr, zi, zr2, zi2, zri;
  logic [W-1:0]    c_re_q, c_im_q;
  logic [IW-1:0]   max_q, iter;
  logic signed [W:0] mag;
  logic            hit_escape, hit_limit;
  logic [W-1:0]    zr_upd, zi_upd;

  assign mag        = $signed({zr2[W-1], zr2}) + $signed({zi2[W-1], zi2});
  assign hit_escape = (mag > MAG_LIMIT);
  assign hit_limit  = (iter == max_q);
  // Wrapping arithmetic: values stay bounded until escape, so no saturation is needed.
  assign zr_upd     = zr2 - zi2 + c_re_q;
  assign zi_upd     = {zri[W-2:0], 1'b0} + c_im_q;
  assign state_dbg  = state;

  always_comb begin
    state_next = state;
    mult_a     = '0;
    mult_b     = '0;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_RR;
      S_RR: begin
        mult_a     = zr;
        mult_b     = zr;
        state_next = S_II;
      end
      S_II: begin
        mult_a     = zi;
        mult_b     = zi;
        state_next = S_RI;
      end
      S_RI: begin
        mult_a     = zr;
        mult_b     = zi;
        state_next = S_UPD;
      end
      S_UPD: state_next = (hit_escape || hit_limit) ? S_DONE : S_RR;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      zr         <= '0;
      zi         <= '0;
      zr2        <= '0;
      zi2        <= '0;
      zri        <= '0;
      iter       <= '0;
      c_re_q     <= '0;
      c_im_q     <= '0;
      max_q      <= '0;
      escaped    <= 1'b0;
      iter_count <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            c_re_q <= c_re;
            c_im_q <= c_im;
            max_q  <= max_iter;
            zr     <= '0;
            zi     <= '0;
            iter   <= '0;
          end
        end
        S_RR: zr2 <= mult_p;
        S_II: zi2 <= mult_p;
        S_RI: zri <= mult_p;
        S_UPD: begin
          if (hit_escape) begin
            escaped    <= 1'b1;
            iter_count <= iter;
          end else if (hit_limit) begin
            escaped    <= 1'b0;
            iter_count <= iter;
          end else begin
            zr   <= zr_upd;
            zi   <= zi_upd;
            iter <= iter + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
